// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state encodings, default widths and bridge address map
package apb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam logic [7:0] CSR_REGION = 8'h00;

    function automatic logic is_csr(input logic [31:0] addr);
        return addr[31:24] == CSR_REGION;
    endfunction
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating wait-state counter flagging the TIMEOUT-th idle ACCESS cycle
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [W-1:0] cnt;

    // cnt holds the waits already seen, so the current wait is the last allowed one at LAST
    assign expired = (TIMEOUT != 0) && en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding host command to APB SETUP/ACCESS requester with timeout
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWrite,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    apb_state_t state, state_n;
    logic expired;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clr    (state == SETUP),
        .en     (state == ACCESS && !PREADY),
        .expired(expired)
    );

    assign cmd_ready = state == IDLE;
    assign rsp_valid = state == RESP;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   state_n = cmd_valid ? SETUP : IDLE;
            SETUP:  state_n = ACCESS;
            ACCESS: state_n = (PREADY || expired) ? RESP : ACCESS;
            RESP:   state_n = rsp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWrite      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state   <= state_n;
            PSEL    <= state_n == SETUP || state_n == ACCESS;
            PENABLE <= state_n == ACCESS;
            // the APB address/data registers double as the latched command
            if (state == IDLE && cmd_valid) begin
                PWrite <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (state == ACCESS && PREADY) begin
                rsp_rdata   <= PWrite ? '0 : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (state == ACCESS && expired) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven and randomized checks of apb_master against a timeline model
module tb_apb_master;
    localparam int TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWrite;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int n_vec = 0;
    int n_err = 0;

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWrite(PWrite), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          waits;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          lat;
    } vec_t;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    // Reference: a transfer either completes after its waits or aborts once TO waits pile up
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.waits >= TO) begin
            r.exp_rdata = '0;
            r.exp_err   = 1'b1;
            r.exp_to    = 1'b1;
            r.lat       = 2 + TO;
        end else begin
            r.exp_rdata = v.wr ? 32'h0 : v.rdata;
            r.exp_err   = v.err;
            r.exp_to    = 1'b0;
            r.lat       = 3 + v.waits;
        end
        return r;
    endfunction

    task automatic run(input vec_t v);
        int a = 0;
        logic rdy;
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        rsp_ready = 0;
        for (int c = 1; c <= v.lat + v.hold; c++) begin
            @(negedge PCLK);
            if (c < v.lat) begin
                chk("psel", PSEL, 1);
                chk("penable", PENABLE, c >= 2);
                chk("rsp_valid_busy", rsp_valid, 0);
                chk("cmd_ready_busy", cmd_ready, 0);
                chk("paddr", PADDR, v.addr);
                chk("pwrite", PWrite, v.wr);
                chk("pwdata", PWDATA, v.wdata);
            end else begin
                chk("psel_resp", PSEL, 0);
                chk("penable_resp", PENABLE, 0);
                chk("rsp_valid", rsp_valid, 1);
                chk("cmd_ready_resp", cmd_ready, 0);
                chk("rsp_rdata", rsp_rdata, v.exp_rdata);
                chk("rsp_err", rsp_err, v.exp_err);
                chk("rsp_timeout", rsp_timeout, v.exp_to);
            end
            cmd_write = 1'($urandom);
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            if (PSEL && PENABLE) a++;
            rdy     = (PSEL && PENABLE) ? (a > v.waits) : 1'($urandom);
            PREADY  = rdy;
            PRDATA  = (rdy && PSEL && PENABLE) ? v.rdata : $urandom;
            PSLVERR = (rdy && PSEL && PENABLE) ? v.err : 1'($urandom);
            if (c == v.lat + v.hold) begin
                rsp_ready = 1;
                cmd_valid = 0;
            end
        end
        @(negedge PCLK);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("rsp_valid_after", rsp_valid, 0);
        chk("psel_after", PSEL, 0);
        rsp_ready = 0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWrite, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
    endtask

    vec_t dir[7];
    vec_t v;

    initial begin
        // wr, addr, wdata, rdata, err, waits, hold, exp_rdata, exp_err, exp_to, lat
        dir[0] = '{1'b1, 32'h0000_0000, 32'h0000_1234, 32'h1111_1111, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0, 3};
        dir[1] = '{1'b0, 32'h0100_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 6};
        dir[2] = '{1'b0, 32'h0000_0008, 32'h0, 32'h0000_0055, 1'b1, 2, 1, 32'h0000_0055, 1'b1, 1'b0, 5};
        dir[3] = '{1'b0, 32'h0300_0004, 32'h0, 32'h7777_7777, 1'b0, 20, 0, 32'h0, 1'b1, 1'b1, 6};
        dir[4] = '{1'b0, 32'h0300_0008, 32'h0, 32'hCAFE_0001, 1'b0, 3, 0, 32'hCAFE_0001, 1'b0, 1'b0, 6};
        dir[5] = '{1'b1, 32'h0400_0000, 32'h5A5A_5A5A, 32'h0, 1'b0, 4, 2, 32'h0, 1'b1, 1'b1, 6};
        dir[6] = '{1'b1, 32'h0500_0010, 32'h0BAD_F00D, 32'h0, 1'b0, 1, 10, 32'h0, 1'b0, 1'b0, 4};

        PRESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 0; PREADY = 0; PRDATA = 0; PSLVERR = 0;
        repeat (2) @(negedge PCLK);
        chk_reset_vals();
        PRESETn = 1;
        @(negedge PCLK);
        chk("cmd_ready_post_reset", cmd_ready, 1);

        for (int i = 0; i < 7; i++) run(dir[i]);

        // reset while the slave stalls in ACCESS
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0200_0010; cmd_wdata = 32'hA5A5_0000;
        PREADY = 0;
        @(negedge PCLK);
        chk("mid_setup_psel", PSEL, 1);
        @(negedge PCLK);
        chk("mid_access_penable", PENABLE, 1);
        PRESETn = 0; cmd_valid = 0;
        @(negedge PCLK);
        chk_reset_vals();
        PRESETn = 1;
        @(negedge PCLK);
        chk("mid_cmd_ready", cmd_ready, 1);
        chk("mid_no_rsp", rsp_valid, 0);
        run(dir[1]);

        for (int i = 0; i < 40; i++) begin
            v.wr    = 1'($urandom);
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.err   = 1'($urandom);
            v.waits = $urandom_range(0, 6);
            v.hold  = $urandom_range(0, 3);
            run(model(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
